// File: rtl/gpio_serial_loader_if.sv
// Signal bundle between the GPIO chain loader, the housekeeping register file
// and the SPI/wishbone bit-bang register path.
interface gpio_serial_loader_if #(
    parameter int CFG_W = 13
);
    logic             xfer_start;
    logic [5:0]       cfg_addr_r;
    logic [5:0]       cfg_addr_l;
    logic [CFG_W-1:0] cfg_data_r;
    logic [CFG_W-1:0] cfg_data_l;
    logic             bb_en;
    logic             bb_clock;
    logic             bb_load;
    logic             bb_resetn;
    logic             bb_data_r;
    logic             bb_data_l;
    logic             serial_clock;
    logic             serial_load;
    logic             serial_resetn;
    logic             serial_data_r;
    logic             serial_data_l;
    logic             busy;
    logic             bb_active;
    logic             done;

    modport slave (
        input  xfer_start, cfg_data_r, cfg_data_l,
               bb_en, bb_clock, bb_load, bb_resetn, bb_data_r, bb_data_l,
        output cfg_addr_r, cfg_addr_l,
               serial_clock, serial_load, serial_resetn, serial_data_r, serial_data_l,
               busy, bb_active, done
    );

    modport master (
        output xfer_start, cfg_data_r, cfg_data_l,
               bb_en, bb_clock, bb_load, bb_resetn, bb_data_r, bb_data_l,
        input  cfg_addr_r, cfg_addr_l,
               serial_clock, serial_load, serial_resetn, serial_data_r, serial_data_l,
               busy, bb_active, done
    );
endinterface

// File: rtl/gpio_serial_loader.sv
// Shifts per-pad config words out on the right/left GPIO chains, pulses load,
// and hands the chain pins to the bit-bang path whenever the sequencer is idle.
module gpio_serial_loader #(
    parameter int NPADS = 19,
    parameter int CFG_W = 13,
    parameter int DIV   = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rstn_i,
    gpio_serial_loader_if.slave  bus
);
    localparam int KW = $clog2(NPADS);
    localparam int BW = $clog2(CFG_W);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO, DONE
    } state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [KW-1:0]    k_q, k_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CFG_W-1:0] sr_r_q, sr_r_d;
    logic [CFG_W-1:0] sr_l_q, sr_l_d;
    logic             serial_clock_q, serial_clock_d;
    logic             serial_load_q, serial_load_d;
    logic             serial_resetn_q, serial_resetn_d;
    logic             serial_data_r_q, serial_data_r_d;
    logic             serial_data_l_q, serial_data_l_d;
    logic             bb_active_q, bb_active_d;
    logic             div_end;
    logic             bb_own;
    logic             shifting;

    assign div_end = (div_q == DW'(DIV - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        pending_d = pending_q | bus.xfer_start;
        k_d       = k_q;
        bit_d     = bit_q;
        div_d     = '0;
        sr_r_d    = sr_r_q;
        sr_l_d    = sr_l_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.bb_en && pending_q) begin
                    pending_d = bus.xfer_start;
                    k_d       = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                sr_r_d  = bus.cfg_data_r;
                sr_l_d  = bus.cfg_data_l;
                bit_d   = BW'(CFG_W - 1);
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) begin
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        state_d = SHIFT_LO;
                    end else if (k_q != KW'(NPADS - 1)) begin
                        k_d     = k_q + KW'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            LOAD_HI: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) state_d = LOAD_LO;
            end
            LOAD_LO: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Chain pins are registered from the next state so they line up with state_q.
        bb_own          = (state_d == IDLE) && bus.bb_en;
        shifting        = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
        bb_active_d     = bb_own;
        serial_clock_d  = bb_own ? bus.bb_clock  : (state_d == SHIFT_HI);
        serial_load_d   = bb_own ? bus.bb_load   : (state_d == LOAD_HI);
        serial_resetn_d = bb_own ? bus.bb_resetn : 1'b1;
        serial_data_r_d = bb_own ? bus.bb_data_r : (shifting && sr_r_d[bit_d]);
        serial_data_l_d = bb_own ? bus.bb_data_l : (shifting && sr_l_d[bit_d]);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q         <= IDLE;
            pending_q       <= 1'b0;
            k_q             <= '0;
            bit_q           <= '0;
            div_q           <= '0;
            sr_r_q          <= '0;
            sr_l_q          <= '0;
            serial_clock_q  <= 1'b0;
            serial_load_q   <= 1'b0;
            serial_resetn_q <= 1'b1;
            serial_data_r_q <= 1'b0;
            serial_data_l_q <= 1'b0;
            bb_active_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            k_q             <= k_d;
            bit_q           <= bit_d;
            div_q           <= div_d;
            sr_r_q          <= sr_r_d;
            sr_l_q          <= sr_l_d;
            serial_clock_q  <= serial_clock_d;
            serial_load_q   <= serial_load_d;
            serial_resetn_q <= serial_resetn_d;
            serial_data_r_q <= serial_data_r_d;
            serial_data_l_q <= serial_data_l_d;
            bb_active_q     <= bb_active_d;
        end
    end

    // Farthest pad first: right chain walks down from NPADS-1, left walks up from NPADS.
    assign bus.cfg_addr_r    = (state_q == FETCH) ? 6'(NPADS - 1 - int'(k_q)) : 6'd0;
    assign bus.cfg_addr_l    = (state_q == FETCH) ? 6'(NPADS + int'(k_q)) : 6'd0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.bb_active     = bb_active_q;
    assign bus.serial_clock  = serial_clock_q;
    assign bus.serial_load   = serial_load_q;
    assign bus.serial_resetn = serial_resetn_q;
    assign bus.serial_data_r = serial_data_r_q;
    assign bus.serial_data_l = serial_data_l_q;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// Drives a DIV=1 and a DIV=3 loader with shared stimulus and checks both against
// a run-position reference model plus a shift-register model of the pad chains.
module tb_gpio_serial_loader;
    localparam int NPADS = 19;
    localparam int CFG_W = 13;
    localparam int CHAIN = NPADS * CFG_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic xfer_start = 1'b0;
    logic bb_en = 1'b0;
    logic bb_clock = 1'b0;
    logic bb_load = 1'b0;
    logic bb_resetn = 1'b1;
    logic bb_data_r = 1'b0;
    logic bb_data_l = 1'b0;

    logic [CFG_W-1:0] mem [2*NPADS];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CHAIN-1:0] exp_chain(input bit left);
        logic [CHAIN-1:0] c;
        c = '0;
        for (int i = 0; i < NPADS; i++)
            c = (c << CFG_W) | CHAIN'(left ? mem[NPADS + i] : mem[NPADS - 1 - i]);
        return c;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int D   = (gi == 0) ? 1 : 3;
        localparam int SEG = 2 + 2 * CFG_W * D;
        localparam int RUN = NPADS * SEG + 2 * D + 1;

        gpio_serial_loader_if #(.CFG_W(CFG_W)) bus ();

        gpio_serial_loader #(.NPADS(NPADS), .CFG_W(CFG_W), .DIV(D)) u_dut (
            .wb_clk_i  (clk),
            .wb_rstn_i (rst_n),
            .bus       (bus.slave)
        );

        assign bus.xfer_start = xfer_start;
        assign bus.bb_en      = bb_en;
        assign bus.bb_clock   = bb_clock;
        assign bus.bb_load    = bb_load;
        assign bus.bb_resetn  = bb_resetn;
        assign bus.bb_data_r  = bb_data_r;
        assign bus.bb_data_l  = bb_data_l;

        // Register file: data appears the cycle after the address.
        always @(posedge clk) begin
            bus.cfg_data_r <= (bus.cfg_addr_r < 6'(2*NPADS)) ? mem[bus.cfg_addr_r] : '0;
            bus.cfg_data_l <= (bus.cfg_addr_l < 6'(2*NPADS)) ? mem[bus.cfg_addr_l] : '0;
        end

        // Reference model: idle/running flag plus position inside the run.
        logic m_run = 1'b0, m_pend = 1'b0, m_own = 1'b0;
        int   m_p = 0;
        logic m_bclk = 1'b0, m_bload = 1'b0, m_brst = 1'b1, m_bdr = 1'b0, m_bdl = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_run <= 1'b0; m_pend <= 1'b0; m_own <= 1'b0; m_p <= 0;
            end else begin
                if (m_run) begin
                    if (m_p == RUN - 1) m_run <= 1'b0;
                    else                m_p   <= m_p + 1;
                    m_pend <= m_pend | xfer_start;
                    m_own  <= (m_p == RUN - 1) && bb_en;
                end else if (!bb_en && m_pend) begin
                    m_run  <= 1'b1;
                    m_p    <= 0;
                    m_pend <= xfer_start;
                    m_own  <= 1'b0;
                end else begin
                    m_pend <= m_pend | xfer_start;
                    m_own  <= bb_en;
                end
                m_bclk <= bb_clock; m_bload <= bb_load; m_brst <= bb_resetn;
                m_bdr  <= bb_data_r; m_bdl <= bb_data_l;
            end
        end

        always @(negedge clk) begin
            int k, o, q, j;
            logic e_clk, e_load, e_rst, e_dr, e_dl, e_busy, e_act, e_done;
            logic [5:0] e_ar, e_al;
            e_clk = 0; e_load = 0; e_rst = 1; e_dr = 0; e_dl = 0;
            e_busy = 0; e_act = 0; e_done = 0; e_ar = 0; e_al = 0;
            if (m_own) begin
                e_clk = m_bclk; e_load = m_bload; e_rst = m_brst;
                e_dr = m_bdr; e_dl = m_bdl; e_act = 1;
            end else if (m_run) begin
                e_busy = 1;
                if (m_p < NPADS * SEG) begin
                    k = m_p / SEG;
                    o = m_p % SEG;
                    if (o == 0) begin
                        e_ar = 6'(NPADS - 1 - k);
                        e_al = 6'(NPADS + k);
                    end else if (o >= 2) begin
                        q     = o - 2;
                        j     = CFG_W - 1 - q / (2 * D);
                        e_clk = (q % (2 * D)) >= D;
                        e_dr  = mem[NPADS - 1 - k][j];
                        e_dl  = mem[NPADS + k][j];
                    end
                end else begin
                    o      = m_p - NPADS * SEG;
                    e_load = (o < D);
                    e_done = (o == 2 * D);
                end
            end
            check($sformatf("div%0d_outputs", D),
                  {bus.serial_clock, bus.serial_load, bus.serial_resetn, bus.serial_data_r,
                   bus.serial_data_l, bus.busy, bus.bb_active, bus.done, bus.cfg_addr_r, bus.cfg_addr_l},
                  {e_clk, e_load, e_rst, e_dr, e_dl, e_busy, e_act, e_done, e_ar, e_al});
        end

        // Physical chain model plus run/pulse measurements.
        logic [CHAIN-1:0] ch_r, ch_l;
        logic p_clk = 1'b0, p_load = 1'b0, p_dr = 1'b0, p_dl = 1'b0;
        int busy_cnt = 0, busy_len = 0, load_cnt = 0, load_w = 0, done_cnt = 0, load_rises = 0;

        always @(negedge clk) begin
            p_clk <= bus.serial_clock; p_load <= bus.serial_load;
            p_dr  <= bus.serial_data_r; p_dl <= bus.serial_data_l;
            if (bus.serial_clock && !p_clk) begin
                ch_r <= {ch_r[CHAIN-2:0], bus.serial_data_r};
                ch_l <= {ch_l[CHAIN-2:0], bus.serial_data_l};
                if (!bus.bb_active)
                    check($sformatf("div%0d_data_stable", D),
                          {bus.serial_data_r, bus.serial_data_l}, {p_dr, p_dl});
            end
            if (bus.serial_load && !p_load) begin
                load_rises <= load_rises + 1;
                if (!bus.bb_active) begin
                    check($sformatf("div%0d_chain_r", D), ch_r, exp_chain(1'b0));
                    check($sformatf("div%0d_chain_l", D), ch_l, exp_chain(1'b1));
                end
            end
            if (bus.busy) busy_cnt <= busy_cnt + 1;
            else if (busy_cnt != 0) begin busy_len <= busy_cnt; busy_cnt <= 0; end
            if (bus.serial_load) load_cnt <= load_cnt + 1;
            else if (load_cnt != 0) begin load_w <= load_cnt; load_cnt <= 0; end
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk) xfer_start = 1'b1;
        @(negedge clk) xfer_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((g_dut[0].m_run || g_dut[0].m_pend || g_dut[1].m_run || g_dut[1].m_pend) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 256'(n >= budget), 256'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0, d1, lr0, lr1;
        logic [2:0] pat;
        for (int i = 0; i < NPADS; i++) begin
            mem[i]         = CFG_W'(16'h1000 | i);
            mem[NPADS + i] = CFG_W'(16'h0A00 | i);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy_d1", g_dut[0].bus.busy, 0);
        check("reset_pins_d3", {g_dut[1].bus.serial_clock, g_dut[1].bus.serial_load,
              g_dut[1].bus.serial_resetn, g_dut[1].bus.serial_data_r, g_dut[1].bus.done}, 5'b00100);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full load with the fixed word pattern
        pulse_start();
        wait_idle(3000);
        check("busy_len_d1", g_dut[0].busy_len, 535);
        check("busy_len_d3", g_dut[1].busy_len, 1527);
        check("done_cnt_d1", g_dut[0].done_cnt, 1);
        check("load_w_d1", g_dut[0].load_w, 1);
        check("load_w_d3", g_dut[1].load_w, 3);
        check("chain_r_far_pad", g_dut[0].ch_r[CHAIN-1 -: CFG_W], 13'h1012);
        check("chain_r_near_pad", g_dut[0].ch_r[CFG_W-1:0], 13'h1000);
        check("chain_l_first_pad", g_dut[1].ch_l[CHAIN-1 -: CFG_W], 13'h0A00);
        check("chain_l_last_pad", g_dut[1].ch_l[CFG_W-1:0], 13'h0A12);

        // Bit-bang ownership; a request meanwhile waits for bb_en to drop
        @(negedge clk) bb_en = 1'b1;
        pat = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            if (i < 2) check("bb_follow_d1", g_dut[0].bus.serial_clock, pat[i+1]);
            bb_clock = pat[i]; bb_data_r = pat[i];
            xfer_start = (i == 1);
        end
        @(negedge clk);
        check("bb_follow_last_d1", {g_dut[0].bus.serial_clock, g_dut[0].bus.serial_data_r}, 2'b11);
        check("bb_active_d3", g_dut[1].bus.bb_active, 1);
        xfer_start = 1'b0;
        repeat (5) @(negedge clk);
        check("bb_no_busy_d1", g_dut[0].bus.busy, 0);
        bb_en = 1'b0; bb_clock = 1'b0; bb_data_r = 1'b0;
        wait_idle(3000);
        check("done_after_bb_d1", g_dut[0].done_cnt, 2);
        check("done_after_bb_d3", g_dut[1].done_cnt, 2);

        // Requests during a run collapse into one re-run
        d0 = g_dut[0].done_cnt; d1 = g_dut[1].done_cnt;
        pulse_start();
        repeat (98) @(negedge clk);
        pulse_start();
        repeat (99) @(negedge clk);
        pulse_start();
        wait_idle(6000);
        check("rerun_done_d1", g_dut[0].done_cnt - d0, 2);
        check("rerun_done_d3", g_dut[1].done_cnt - d1, 2);

        // Asynchronous reset mid-sequence
        lr0 = g_dut[0].load_rises; lr1 = g_dut[1].load_rises;
        pulse_start();
        repeat (299) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_d1", {g_dut[0].bus.busy, g_dut[0].bus.serial_clock, g_dut[0].bus.serial_resetn,
              g_dut[0].bus.serial_data_r, g_dut[0].bus.cfg_addr_r}, 10'b0010_000000);
        check("async_rst_busy_d3", g_dut[1].bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_load_after_abort_d1", g_dut[0].load_rises, lr0);
        check("no_load_after_abort_d3", g_dut[1].load_rises, lr1);
        check("idle_after_abort_d3", g_dut[1].bus.busy, 0);

        // bb_en mid-sequence is ignored until DONE
        pulse_start();
        repeat (150) @(negedge clk);
        bb_en = 1'b1;
        wait_idle(3000);
        check("bb_after_done_d1", g_dut[0].bus.bb_active, 1);
        check("bb_after_done_d3", g_dut[1].bus.bb_active, 1);
        bb_en = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized words and request/bit-bang traffic
        for (int i = 0; i < 2*NPADS; i++) mem[i] = CFG_W'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            xfer_start = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 249) == 0) bb_en = ~bb_en;
            bb_clock  = 1'($urandom); bb_load   = 1'($urandom);
            bb_resetn = 1'($urandom); bb_data_r = 1'($urandom);
            bb_data_l = 1'($urandom);
        end
        @(negedge clk);
        xfer_start = 1'b0; bb_en = 1'b0; bb_load = 1'b0; bb_resetn = 1'b1;
        wait_idle(6000);
        pulse_start();
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
